// File: rtl/code_pulse_tx.sv
// Serial pulse-count transmitter: sends data as a burst of 1-cycle pulses on x,
// each followed by GAP low cycles, then a GUARD low interval and a done strobe.
// Optional start marker (x high for 2 cycles, then GAP low) with CODE_PULSE_TX_MARKER_EN.
module code_pulse_tx #(
  parameter int WIDTH = 4,
  parameter int GAP   = 3,
  parameter int GUARD = 4
) (
  input  logic             cp,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sent,
  output logic [2:0]       dbg_state
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GRD_W = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP - 1);
  localparam logic [GRD_W-1:0] GUARD_LAST = GRD_W'(GUARD - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PULSE  = 3'd1,
    S_GAPW   = 3'd2,
`ifdef CODE_PULSE_TX_MARKER_EN
    S_MARK   = 3'd4,
`endif
    S_GUARDW = 3'd3
  } state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_remaining, w_remaining_d;
  logic [WIDTH-1:0] r_sent, w_sent_d;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_d;
  logic [GRD_W-1:0] r_guard_cnt, w_guard_cnt_d;
  logic             r_x, w_x_d;
  logic             r_done, w_done_d;
  logic             w_accept;
  logic             w_enter_pulse;
`ifdef CODE_PULSE_TX_MARKER_EN
  logic             r_mark_cnt, w_mark_cnt_d;
`endif

  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge cp or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef CODE_PULSE_TX_MARKER_EN
          w_next = S_MARK;
`else
          w_next = (data != '0) ? S_PULSE : S_GUARDW;
`endif
        end
      end
      S_PULSE: w_next = S_GAPW;
      // remaining was already decremented when the last pulse was emitted
      S_GAPW: begin
        if (r_gap_cnt == GAP_LAST) w_next = (r_remaining != '0) ? S_PULSE : S_GUARDW;
      end
      S_GUARDW: begin
        if (r_guard_cnt == GUARD_LAST) w_next = S_IDLE;
      end
`ifdef CODE_PULSE_TX_MARKER_EN
      S_MARK: begin
        if (r_mark_cnt) w_next = S_GAPW;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // x, sent and done are registered from the next state so they line up with it
  always_comb begin
    w_enter_pulse = (w_next == S_PULSE);
`ifdef CODE_PULSE_TX_MARKER_EN
    w_x_d         = w_enter_pulse || (w_next == S_MARK);
    w_mark_cnt_d  = (r_state == S_MARK) && (w_next == S_MARK);
`else
    w_x_d         = w_enter_pulse;
`endif
    w_done_d      = (r_state == S_GUARDW) && (w_next == S_IDLE);
    w_gap_cnt_d   = ((r_state == S_GAPW) && (w_next == S_GAPW)) ? r_gap_cnt + 1'b1 : '0;
    w_guard_cnt_d = ((r_state == S_GUARDW) && (w_next == S_GUARDW)) ? r_guard_cnt + 1'b1 : '0;
    w_remaining_d = w_accept ? data : r_remaining;
    w_sent_d      = w_accept ? '0 : r_sent;
    if (w_enter_pulse) begin
      w_remaining_d = w_remaining_d - 1'b1;
      w_sent_d      = w_sent_d + 1'b1;
    end
  end

  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      r_x         <= 1'b0;
      r_done      <= 1'b0;
      r_sent      <= '0;
      r_remaining <= '0;
      r_gap_cnt   <= '0;
      r_guard_cnt <= '0;
`ifdef CODE_PULSE_TX_MARKER_EN
      r_mark_cnt  <= 1'b0;
`endif
    end else begin
      r_x         <= w_x_d;
      r_done      <= w_done_d;
      r_sent      <= w_sent_d;
      r_remaining <= w_remaining_d;
      r_gap_cnt   <= w_gap_cnt_d;
      r_guard_cnt <= w_guard_cnt_d;
`ifdef CODE_PULSE_TX_MARKER_EN
      r_mark_cnt  <= w_mark_cnt_d;
`endif
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign busy      = ~ready;
  assign x         = r_x;
  assign done      = r_done;
  assign sent      = r_sent;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_code_pulse_tx.sv
// Bench for code_pulse_tx: randomized frames against a frame-timing model; expected
// x pulses and done strobes are queued at issue time and checked by a negedge monitor.
module tb_code_pulse_tx;
  localparam int WIDTH = 4;
  localparam int GAP   = 3;
  localparam int GUARD = 4;
  localparam int EW    = 32 + WIDTH;
`ifdef CODE_PULSE_TX_MARKER_EN
  localparam int MARK_OFF = 2 + GAP;
`else
  localparam int MARK_OFF = 0;
`endif

  logic             cp;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data;
  logic             ready, x, busy, done;
  logic [WIDTH-1:0] sent;
  logic [2:0]       dbg_state;

  code_pulse_tx #(.WIDTH(WIDTH), .GAP(GAP), .GUARD(GUARD)) dut (
    .cp(cp), .reset(reset), .start(start), .data(data),
    .ready(ready), .x(x), .busy(busy), .done(done), .sent(sent),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  int cyc = 0;
  always @(posedge cp) cyc <= cyc + 1;

  // scoreboard state
  logic [EW-1:0] exp_x_q[$];
  logic [EW-1:0] exp_done_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 0;
  int m_accept_edge = 0;
  int m_done_cyc    = 0;
  int m_cur_n       = 0;
  int m_prev_n      = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [EW-1:0] mk(int c, int s);
    return {c[31:0], s[WIDTH-1:0]};
  endfunction

  function automatic int ent_cyc(logic [EW-1:0] e);
    return int'(e[EW-1:WIDTH]);
  endfunction

  function automatic int frame_len(int n);
    return n * (1 + GAP) + GUARD + MARK_OFF;
  endfunction

  function automatic int pulse_cyc(int e, int k);
    return e + MARK_OFF + k * (1 + GAP);
  endfunction

  function automatic int exp_sent_at(int c);
    int cnt;
    if (c < m_accept_edge) return m_prev_n;
    cnt = 0;
    for (int k = 0; k < m_cur_n; k++)
      if (pulse_cyc(m_accept_edge, k) <= c) cnt++;
    return cnt;
  endfunction

  function automatic void model_clear();
    exp_x_q.delete();
    exp_done_q.delete();
    m_accept_edge = 0;
    m_done_cyc    = 0;
    m_cur_n       = 0;
    m_prev_n      = 0;
  endfunction

  // driver tasks: each returns at posedge+2 of a new cycle
  task automatic tick();
    @(posedge cp);
    #2;
  endtask

  task automatic issue_start(input int n);
    int e;
    start = 1'b1;
    data  = n[WIDTH-1:0];
    if (cyc >= m_done_cyc) begin
      e = cyc + 1;
`ifdef CODE_PULSE_TX_MARKER_EN
      exp_x_q.push_back(mk(e, 0));
      exp_x_q.push_back(mk(e + 1, 0));
`endif
      for (int k = 0; k < n; k++) exp_x_q.push_back(mk(pulse_cyc(e, k), k + 1));
      exp_done_q.push_back(mk(e + frame_len(n), n));
      m_prev_n      = m_cur_n;
      m_cur_n       = n;
      m_accept_edge = e;
      m_done_cyc    = e + frame_len(n);
    end
    tick();
    start = 1'b0;
    data  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && cyc < m_done_cyc; i++) tick();
  endtask

  // monitor
  always @(negedge cp) begin
    logic [EW-1:0] ent;
    bit exp_rdy;
    if (mon_en && reset) begin
      exp_rdy = !(cyc >= m_accept_edge && cyc < m_done_cyc);
      chk("ready", {31'd0, ready}, {31'd0, exp_rdy});
      chk("busy", {31'd0, busy}, {31'd0, !exp_rdy});
      chk("sent", 32'(sent), 32'(exp_sent_at(cyc)));
      while (exp_x_q.size() > 0 && ent_cyc(exp_x_q[0]) < cyc) begin
        n_vec++; n_err++;
        $display("FAIL missed_x: no pulse at cyc %0d, want x=1", ent_cyc(exp_x_q[0]));
        void'(exp_x_q.pop_front());
      end
      if (x) begin
        if (exp_x_q.size() == 0 || ent_cyc(exp_x_q[0]) != cyc) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_x at cyc %0d: got x=1, want x=0", cyc);
        end else begin
          ent = exp_x_q.pop_front();
          chk("sent_at_pulse", 32'(sent), 32'(ent[WIDTH-1:0]));
        end
      end
      while (exp_done_q.size() > 0 && ent_cyc(exp_done_q[0]) < cyc) begin
        n_vec++; n_err++;
        $display("FAIL missed_done: no done at cyc %0d, want done=1", ent_cyc(exp_done_q[0]));
        void'(exp_done_q.pop_front());
      end
      if (done) begin
        if (exp_done_q.size() == 0 || ent_cyc(exp_done_q[0]) != cyc) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done at cyc %0d: got done=1, want done=0", cyc);
        end else begin
          ent = exp_done_q.pop_front();
          chk("sent_at_done", 32'(sent), 32'(ent[WIDTH-1:0]));
        end
      end
    end
  end

  // stimulus
  initial begin
    int e, n, pc;
    reset = 1'b0;
    start = 1'b0;
    data  = '0;
    repeat (3) tick();
    chk("rst_x", {31'd0, x}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sent", 32'(sent), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (10) tick();

    // single frame of 3, then zero count
    issue_start(3);
    e = cyc;
    for (int i = 0; i < frame_len(3); i++) tick();
    chk("done_3", {31'd0, done}, 32'd1);
    chk("ready_done_3", {31'd0, ready}, 32'd1);
    repeat (2) tick();
    issue_start(0);
    wait_idle();
    chk("done_0", {31'd0, done}, 32'd1);
    tick();

    // ignored start mid-frame, then back-to-back in the done cycle
    issue_start(2);
    repeat (2) tick();
    issue_start(9);
    wait_idle();
    issue_start(1);
    wait_idle();
    tick();

    // max count
    issue_start(15);
    wait_idle();
    chk("done_15", {31'd0, done}, 32'd1);
    chk("sent_15", 32'(sent), 32'd15);
    repeat (2) tick();

    // asynchronous abort during the second pulse
    issue_start(5);
    e = cyc - 1 + 1;
    pc = pulse_cyc(m_accept_edge, 1);
    while (cyc < pc) tick();
    chk("x_before_abort", {31'd0, x}, 32'd1);
    mon_en = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("abort_x", {31'd0, x}, 32'd0);
    chk("abort_sent", 32'(sent), 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    model_clear();
    repeat (3) begin
      tick();
      chk("abort_hold_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b1;
    mon_en = 1'b1;
    tick();
    issue_start(2);
    wait_idle();
    tick();

    // randomized frames with spurious starts and back-to-back issue
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, (1 << WIDTH) - 1);
      issue_start(n);
      if ($urandom_range(0, 2) == 0 && cyc + 2 < m_done_cyc) begin
        repeat ($urandom_range(0, 1)) tick();
        issue_start($urandom_range(0, (1 << WIDTH) - 1));
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end

    wait_idle();
    repeat (4) tick();
    chk("x_queue_drained", 32'(exp_x_q.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
